// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW/HI-LO stall, exception flush and mult/div busy tracking
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IDrs,
    input  logic [4:0] IDrt,
    input  logic [1:0] IDtuse_rs,
    input  logic [1:0] IDtuse_rt,
    input  logic       IDmd_start,
    input  logic       IDmd_div,
    input  logic       IDhilo_acc,
    input  logic       EXregwrite,
    input  logic [4:0] EXdst,
    input  logic [1:0] EXt_new,
    input  logic       MEMregwrite,
    input  logic [4:0] MEMdst,
    input  logic [1:0] MEMt_new,
    input  logic       except_req,
    output logic       IFstall,
    output logic       IDstall,
    output logic       IFflush,
    output logic       EXflush,
    output logic       MEMflush,
    output logic       md_busy,
    output logic       md_done
);

    localparam int CW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            hz_rs;
    logic            hz_rt;
    logic            md_stall;
    logic            stall;
    logic            flush;

    // A producer only blocks when its result arrives later than the consumer needs it.
    assign hz_rs = (IDrs != 5'd0) &&
                   ((EXregwrite  && (EXdst  == IDrs) && (EXt_new  > IDtuse_rs)) ||
                    (MEMregwrite && (MEMdst == IDrs) && (MEMt_new > IDtuse_rs)));
    assign hz_rt = (IDrt != 5'd0) &&
                   ((EXregwrite  && (EXdst  == IDrt) && (EXt_new  > IDtuse_rt)) ||
                    (MEMregwrite && (MEMdst == IDrt) && (MEMt_new > IDtuse_rt)));

    assign md_stall = md_busy && (IDmd_start || IDhilo_acc);
    assign flush    = reset || except_req;
    assign stall    = (hz_rs || hz_rt || md_stall) && !flush;

    assign IFstall  = stall;
    assign IDstall  = stall;
    assign IFflush  = flush;
    assign EXflush  = flush || stall;
    assign MEMflush = flush;

    // md_done is set on the edge that leaves cnt at 1, so it is high during the last busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (IDmd_start && !stall && !except_req) begin
                        state   <= BUSY;
                        md_busy <= 1'b1;
                        cnt     <= IDmd_div ? DIV_CNT : MUL_CNT;
                        md_done <= IDmd_div ? (DIV_LAT == 1) : (MUL_LAT == 1);
                    end
                end
                BUSY: begin
                    if (except_req || (cnt == CW'(1))) begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt     <= cnt - CW'(1);
                        md_done <= (cnt == CW'(2));
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IDrs, IDrt, EXdst, MEMdst;
    logic [1:0] IDtuse_rs, IDtuse_rt, EXt_new, MEMt_new;
    logic       IDmd_start, IDmd_div, IDhilo_acc, EXregwrite, MEMregwrite, except_req;
    logic       IFstall, IDstall, IFflush, EXflush, MEMflush, md_busy, md_done;
    logic [6:0] outs;

    int         n_cmp = 0;
    int         n_err = 0;
    string      tag_q[$];
    logic [6:0] val_q[$];

    // {IFstall, IDstall, IFflush, EXflush, MEMflush, md_busy, md_done}
    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] STALL = 7'b1101000;
    localparam logic [6:0] FLUSH = 7'b0011100;
    localparam logic [6:0] BUSY  = 7'b0000010;
    localparam logic [6:0] DONE  = 7'b0000001;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MUL_LAT(5), .DIV_LAT(32)) dut (
        .clk(clk), .reset(reset),
        .IDrs(IDrs), .IDrt(IDrt), .IDtuse_rs(IDtuse_rs), .IDtuse_rt(IDtuse_rt),
        .IDmd_start(IDmd_start), .IDmd_div(IDmd_div), .IDhilo_acc(IDhilo_acc),
        .EXregwrite(EXregwrite), .EXdst(EXdst), .EXt_new(EXt_new),
        .MEMregwrite(MEMregwrite), .MEMdst(MEMdst), .MEMt_new(MEMt_new),
        .except_req(except_req),
        .IFstall(IFstall), .IDstall(IDstall), .IFflush(IFflush), .EXflush(EXflush),
        .MEMflush(MEMflush), .md_busy(md_busy), .md_done(md_done)
    );

    assign outs = {IFstall, IDstall, IFflush, EXflush, MEMflush, md_busy, md_done};

    task automatic push(input string tag, input logic [6:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic drain();
        string      t;
        logic [6:0] e;
        #1;
        while (val_q.size() > 0) begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            n_cmp++;
            assert (outs === e) else begin
                n_err++;
                $error("FAIL %s: observed %b expected %b", t, outs, e);
            end
        end
    endtask

    task automatic clear_inputs();
        IDrs = 0; IDrt = 0; IDtuse_rs = 2'd3; IDtuse_rt = 2'd3;
        IDmd_start = 0; IDmd_div = 0; IDhilo_acc = 0;
        EXregwrite = 0; EXdst = 0; EXt_new = 0;
        MEMregwrite = 0; MEMdst = 0; MEMt_new = 0;
        except_req = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        push("reset_state", FLUSH); drain();
        @(negedge clk); reset = 1'b0;
        push("idle_after_reset", NONE); drain();

        @(negedge clk);
        EXregwrite = 1; EXdst = 5; EXt_new = 2; IDrs = 5; IDtuse_rs = 1;
        push("load_use_stall", STALL); drain();
        EXt_new = 1;
        push("load_use_tnew_eq_tuse", NONE); drain();
        EXt_new = 3; IDtuse_rs = 3;
        push("tuse3_never_stalls", NONE); drain();
        EXdst = 0; IDrs = 0; EXt_new = 2; IDtuse_rs = 0;
        push("zero_reg_source", NONE); drain();

        clear_inputs();
        MEMregwrite = 1; MEMdst = 7; MEMt_new = 1; IDrt = 7; IDtuse_rt = 0;
        push("mem_rt_stall", STALL); drain();
        IDtuse_rt = 1;
        push("mem_rt_no_stall", NONE); drain();
        IDtuse_rt = 0; except_req = 1;
        push("except_over_stall", FLUSH); drain();

        // start blocked by a data hazard must not be accepted
        clear_inputs();
        EXregwrite = 1; EXdst = 9; EXt_new = 2; IDrs = 9; IDtuse_rs = 0; IDmd_start = 1;
        push("start_blocked_by_hazard", STALL); drain();
        @(negedge clk); clear_inputs();
        push("start_blocked_not_busy", NONE); drain();

        // mult: accepted at edge 0, busy cycles 1..5, done in cycle 5
        IDmd_start = 1; IDmd_div = 0;
        push("mult_start", NONE); drain();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); clear_inputs();
            if (k == 3) IDmd_start = 1; else IDhilo_acc = 1;
            push($sformatf("mult_cycle%0d", k), STALL | BUSY | ((k == 5) ? DONE : NONE));
            drain();
        end
        @(negedge clk); clear_inputs(); IDhilo_acc = 1;
        push("mfhi_after_mult", NONE); drain();

        // full div
        clear_inputs(); IDmd_start = 1; IDmd_div = 1;
        push("div_start", NONE); drain();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk); clear_inputs();
            push($sformatf("div_cycle%0d", k), BUSY | ((k == 32) ? DONE : NONE));
            drain();
        end
        @(negedge clk);
        push("div_finished", NONE); drain();

        // div aborted by exception at busy cycle 10
        IDmd_start = 1; IDmd_div = 1;
        push("div2_start", NONE); drain();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk); clear_inputs();
            push($sformatf("div2_cycle%0d", k), BUSY); drain();
        end
        @(negedge clk); except_req = 1;
        push("except_in_busy", FLUSH | BUSY); drain();
        for (int k = 11; k <= 36; k++) begin
            @(negedge clk); clear_inputs();
            push($sformatf("aborted_cycle%0d", k), NONE); drain();
        end

        // start together with exception in IDLE is ignored
        IDmd_start = 1; IDmd_div = 0; except_req = 1;
        push("start_with_except", FLUSH); drain();
        @(negedge clk); clear_inputs();
        push("start_with_except_ignored", NONE); drain();

        // async reset mid-div
        IDmd_start = 1; IDmd_div = 1;
        push("div3_start", NONE); drain();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); clear_inputs();
            push($sformatf("div3_cycle%0d", k), BUSY); drain();
        end
        #2 reset = 1'b1;
        push("async_reset_mid_div", FLUSH); drain();
        @(negedge clk); reset = 1'b0;
        push("after_reset_idle", NONE); drain();
        IDmd_start = 1; IDmd_div = 0;
        push("mult2_start", NONE); drain();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); clear_inputs();
            push($sformatf("mult2_cycle%0d", k), BUSY | ((k == 5) ? DONE : NONE)); drain();
        end
        @(negedge clk);
        push("mult2_finished", NONE); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
